// File: rtl/bus_master_arbiter_pkg.sv
// Shared types for the two-master bus arbiter.
// State encodings and master index constants.
package bus_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int LAT_W = 4;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin chooser for two requesters.
// On a tie the master that did not win last time is picked.
module bus_rr_pick
  import bus_master_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = M_CPU;
    unique case (1'b1)
      (req == 2'b11): gnt_idx = ~last_grant;
      (req == 2'b10): gnt_idx = M_DMA;
      default:        gnt_idx = M_CPU;
    endcase
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Two-master round-robin arbiter in front of the bus bridge.
// One transfer at a time: IDLE -> ADDR -> (WAIT) -> DONE.
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_busy,
  output logic              bus_owner
);

  localparam logic [LAT_W-1:0] LAT_INIT =
    (READ_LAT > 1) ? LAT_W'(READ_LAT - 2) : '0;

  state_t           state;
  logic             last_grant;
  logic [LAT_W-1:0] lat_cnt;
  logic             gnt_valid;
  logic             gnt_idx;

  bus_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign bus_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_wdata  <= '0;
      bus_owner  <= M_CPU;
      last_grant <= M_DMA;
      lat_cnt    <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          bus_we <= 1'b0;
          if (gnt_valid) begin
            state      <= ADDR;
            bus_owner  <= gnt_idx;
            last_grant <= gnt_idx;
            bus_addr   <= gnt_idx ? m1_addr : m0_addr;
            bus_we     <= gnt_idx ? m1_we : m0_we;
            bus_wdata  <= gnt_idx ? m1_wdata : m0_wdata;
          end
        end
        ADDR: begin
          bus_we <= 1'b0;
          if (bus_we || READ_LAT == 1) begin
            state  <= DONE;
            m0_ack <= (bus_owner == M_CPU);
            m1_ack <= (bus_owner == M_DMA);
            if (!bus_we) begin
              if (bus_owner == M_DMA) m1_rdata <= bus_rdata;
              else                    m0_rdata <= bus_rdata;
            end
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state  <= DONE;
            m0_ack <= (bus_owner == M_CPU);
            m1_ack <= (bus_owner == M_DMA);
            if (bus_owner == M_DMA) m1_rdata <= bus_rdata;
            else                    m0_rdata <= bus_rdata;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
